// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start(0), DATA_W data bits LSB-first, parity, STOP_BITS stop(1) bits.
// Define FRAME_TX_ODD_PARITY_EN for odd parity; default build sends even parity.
module parity_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic              r_tx;
    logic              r_done;

    logic              w_parity;
    logic              w_bitEnd;
    logic [DATA_W-1:0] w_shiftNext;

`ifdef FRAME_TX_ODD_PARITY_EN
    assign w_parity = ~(^in_data);
`else
    assign w_parity = ^in_data;
`endif

    assign w_bitEnd    = (r_cnt == CNT_LAST);
    assign w_shiftNext = r_shift >> 1;

    // tx is loaded one bit ahead at each boundary so the line is purely registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cnt <= w_bitEnd ? '0 : r_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (in_valid) begin
                        r_shift  <= in_data;
                        r_parity <= w_parity;
                        r_tx     <= 1'b0;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_bitEnd) begin
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bitEnd) begin
                        if (r_idx == DATA_LAST) begin
                            r_idx   <= '0;
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= w_shiftNext;
                            r_tx    <= w_shiftNext[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bitEnd) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // r_idx counts stop bits here; frame_done coincides with the return to idle
                    if (w_bitEnd) begin
                        if (r_idx == STOP_LAST) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tx         = r_tx;
    assign frame_done = r_done;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx at default parameters (8 data bits, 4 clocks/bit, 1 stop bit).
// Expected parities are hand-computed even parities, inverted when FRAME_TX_ODD_PARITY_EN is defined.
module tb_parity_frame_tx;

`ifdef FRAME_TX_ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    parity_frame_tx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (4),
        .STOP_BITS    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present a word at a falling edge; the following rising edge is the handshake when idle
    task automatic applyStimulus(input logic [7:0] data);
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the handshake edge; ends on the falling edge of the frame_done cycle.
    // mode 0: drop in_valid; mode 1: keep in_valid high and load nextData; mode 2: disturb inputs mid-frame
    task automatic checkFrame(input logic [7:0] data, input logic evenPar, input int mode,
                              input logic [7:0] nextData);
        logic [10:0] bits;
        bits = {1'b1, evenPar ^ ODD, data, 1'b0};
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            checkOutput($sformatf("tx cyc%0d bit%0d", k, k / 4), tx, bits[k/4]);
            checkOutput($sformatf("in_ready cyc%0d", k), in_ready, 0);
            checkOutput($sformatf("busy cyc%0d", k), busy, 1);
            checkOutput($sformatf("frame_done cyc%0d", k), frame_done, 0);
            if (k == 0 && mode != 1) in_valid = 1'b0;
            if (mode == 1 && k == 5) in_data = nextData;
            if (mode == 2) begin
                if (k == 10 || k == 25) in_data = ~in_data;
                if (k == 15) in_valid = 1'b1;
                if (k == 17) in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("frame_done pulse", frame_done, 1);
        checkOutput("in_ready after frame", in_ready, 1);
        checkOutput("busy after frame", busy, 0);
        checkOutput("tx gap after frame", tx, 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset tx", tx, 1);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_done", frame_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle tx", tx, 1);
        checkOutput("idle busy", busy, 0);

        // 0xA5: four ones, even parity 0
        applyStimulus(8'hA5);
        checkFrame(8'hA5, 1'b0, 0, 8'h00);

        // 0x07: three ones, even parity 1
        applyStimulus(8'h07);
        checkFrame(8'h07, 1'b1, 0, 8'h00);

        // Back-to-back 0x00 then 0xFF with in_valid held high
        applyStimulus(8'h00);
        checkFrame(8'h00, 1'b0, 1, 8'hFF);
        @(posedge clk);
        checkFrame(8'hFF, 1'b0, 0, 8'h00);

        // Abort at cycle 20 of a 0x55 frame
        @(negedge clk);
        applyStimulus(8'h55);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
        end
        checkOutput("pre-abort busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort tx", tx, 1);
        checkOutput("abort in_ready", in_ready, 1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort frame_done", frame_done, 0);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checkOutput($sformatf("post-abort frame_done %0d", k), frame_done, 0);
            checkOutput($sformatf("post-abort tx %0d", k), tx, 1);
        end

        // 0x3C after the abort: four ones, even parity 0
        applyStimulus(8'h3C);
        checkFrame(8'h3C, 1'b0, 0, 8'h00);

        // 0x96 with in_data toggled and in_valid pulsed mid-frame: four ones, even parity 0
        applyStimulus(8'h96);
        checkFrame(8'h96, 1'b0, 2, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("no extra frame busy %0d", k), busy, 0);
            checkOutput($sformatf("no extra frame tx %0d", k), tx, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
